// File: rtl/rv32_pkg.sv
// rv32_pkg: shared register-file write record and register constants
package rv32_pkg;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } rf_wr_t;
    localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/lu_result_fifo.sv
// lu_result_fifo: DEPTH-entry FIFO of LU results; ports clk, reset (async), push/wdata, pop/rdata, full, empty
module lu_result_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  rf_wr_t wdata,
    output rf_wr_t rdata,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    rf_wr_t mem [DEPTH];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    // extra wrap bit differs while the index bits match: pointers are a full lap apart
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the regfile write port between WB and the LU result FIFO, tracks LU-owed registers, raises hazard/starvation stalls
//   in : clk, reset (async), RegWriteW/RdW/ResultW, lu_valid/lu_rd/lu_data, issue_valid/issue_rd, Rs1D/Rs2D/RdD/RegWriteD
//   out: lu_ready, rf_we/rf_a3/rf_wd, pending, stall_hazD, stall_starve, conflict_cnt (only with RF_ARB_PERF_EN)
module rf_write_arbiter
    import rv32_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        RegWriteD,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic [31:0] pending,
    output logic        stall_hazD,
    output logic        stall_starve
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0] conflict_cnt
`endif
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    rf_wr_t head;
    logic full, empty, push, pop, pipe_req, lu_wr;
    logic [31:0] set_mask, clr_mask;
    logic [CW-1:0] starve_cnt;
    lu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ('{rd: lu_rd, data: lu_data}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        pipe_req = RegWriteW && (RdW != REG_X0);
        pop      = !empty && !pipe_req;
        // an x0 entry still consumes its pop slot but never reaches the regfile
        lu_wr    = pop && (head.rd != REG_X0);
        push     = lu_valid && !full;
        lu_ready = !full;
        rf_we    = pipe_req || lu_wr;
        rf_a3    = pipe_req ? RdW : lu_wr ? head.rd : REG_X0;
        rf_wd    = pipe_req ? ResultW : lu_wr ? head.data : 32'd0;
        set_mask = (issue_valid && issue_rd != REG_X0) ? 32'd1 << issue_rd : 32'd0;
        clr_mask = lu_wr ? 32'd1 << head.rd : 32'd0;
        stall_hazD   = pending[Rs1D] || pending[Rs2D] || (RegWriteD && pending[RdD]);
        stall_starve = starve_cnt >= CW'(STARVE_LIMIT);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            starve_cnt <= '0;
        end else begin
            // OR-ing the set after the clear lets a same-cycle reissue win
            pending    <= (pending & ~clr_mask) | set_mask;
            starve_cnt <= (empty || pop) ? '0 : stall_starve ? starve_cnt : starve_cnt + CW'(1);
        end
    end
`ifdef RF_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) conflict_cnt <= '0;
        else if (!empty && pipe_req) conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and random checks of rf_write_arbiter against a queue-based reference model
module tb_rf_write_arbiter;
    import rv32_pkg::*;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;
    logic        clk = 0, reset = 1;
    logic        RegWriteW, lu_valid, issue_valid, RegWriteD;
    logic [4:0]  RdW, lu_rd, issue_rd, Rs1D, Rs2D, RdD;
    logic [31:0] ResultW, lu_data;
    logic        lu_ready, rf_we, stall_hazD, stall_starve;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd, pending;
`ifdef RF_ARB_PERF_EN
    logic [31:0] conflict_cnt;
`endif
    always #5 clk = ~clk;
    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .pending(pending),
        .stall_hazD(stall_hazD), .stall_starve(stall_starve)
`ifdef RF_ARB_PERF_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );
    logic [4:0]  q_rd[$];
    logic [31:0] q_d[$];
    logic [4:0]  owed[$];
    bit          pend[32];
    int          lost, n_chk, n_err;
    bit          bubble, pushed;
    logic [31:0] conf;
    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask
    task automatic idle();
        RegWriteW = 0; RdW = 0; ResultW = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
        issue_valid = 0; issue_rd = 0; Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0;
    endtask
    task automatic model_clear();
        q_rd.delete(); q_d.delete(); owed.delete();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        lost = 0; bubble = 0; conf = 0;
    endtask
    task automatic step();
        bit pipe, pop, wr, exp_starve;
        logic [4:0] prd;
        @(negedge clk);
        pipe = RegWriteW && RdW != 0;
        pop  = !pipe && q_rd.size() > 0;
        prd  = pop ? q_rd[0] : 5'd0;
        wr   = pipe || prd != 0;
        exp_starve = lost >= LIM;
        chk("rf_we", 32'(rf_we), 32'(wr));
        chk("rf_a3", 32'(rf_a3), pipe ? 32'(RdW) : 32'(prd));
        chk("rf_wd", rf_wd, pipe ? ResultW : prd != 0 ? q_d[0] : 32'd0);
        chk("lu_ready", 32'(lu_ready), 32'(q_rd.size() < DEPTH));
        chk("pending", pending, pend_vec());
        chk("stall_hazD", 32'(stall_hazD), 32'(pend[Rs1D] || pend[Rs2D] || (RegWriteD && pend[RdD])));
        chk("stall_starve", 32'(stall_starve), 32'(exp_starve));
`ifdef RF_ARB_PERF_EN
        chk("conflict_cnt", conflict_cnt, conf);
`endif
        if (issue_valid && issue_rd != 0 && pend[issue_rd])
            chk("issue_to_pending", 32'(prd == issue_rd), 32'd1);
        pushed = 0;
        if (!reset) begin
            pushed = lu_valid && q_rd.size() < DEPTH;
            lost = (q_rd.size() == 0 || pop) ? 0 : (lost < LIM ? lost + 1 : LIM);
            if (q_rd.size() > 0 && pipe) conf++;
            if (pop) begin
                pend[prd] = 0;
                void'(q_rd.pop_front());
                void'(q_d.pop_front());
            end
            if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
            if (pushed) begin
                q_rd.push_back(lu_rd);
                q_d.push_back(lu_data);
            end
        end
        bubble = exp_starve;
        pend[0] = 0;
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [4:0] rd);
        idle(); issue_valid = 1; issue_rd = rd; step(); idle();
    endtask
    task automatic lu(input logic [4:0] rd, input logic [31:0] d);
        idle(); lu_valid = 1; lu_rd = rd; lu_data = d; step(); idle();
    endtask
    initial begin
        n_chk = 0; n_err = 0;
        model_clear();
        idle();
        step();
        step();
        reset = 0;
        step();
        // 1: single LU round trip
        issue(5'd5);
        lu(5'd5, 32'h1234);
        step();
        step();
        // 2: pipeline starves the FIFO until a bubble
        issue(5'd7);
        lu(5'd7, 32'h7777);
        for (int k = 0; k < 9; k++) begin
            RegWriteW = !bubble; RdW = 5'd3; ResultW = $urandom;
            step();
        end
        idle(); step();
        // 3: full FIFO back-pressure and ordering
        issue(5'd10); issue(5'd11); issue(5'd12);
        RegWriteW = 1; RdW = 3; ResultW = 32'hA; lu_valid = 1; lu_rd = 10; lu_data = 32'h10; step();
        lu_rd = 11; lu_data = 32'h11; step();
        lu_rd = 12; lu_data = 32'h12; step();
        chk("held_not_pushed", 32'(pushed), 32'd0);
        RegWriteW = 0;
        for (int k = 0; k < 10 && !pushed; k++) step();
        chk("lu_push_timeout", 32'(pushed), 32'd1);
        idle();
        repeat (4) step();
        // 4: hazard detection
        issue(5'd9);
        Rs2D = 9; step();
        Rs2D = 0; RdD = 9; RegWriteD = 1; step();
        RegWriteD = 0; step();
        lu(5'd9, 32'h99);
        step(); step();
        // 5: reissue while popping, and x0 LU entry
        issue(5'd4);
        lu(5'd4, 32'h44);
        issue(5'd4);
        step();
        lu(5'd4, 32'h45);
        step(); step();
        lu(5'd0, 32'hDEAD);
        step(); step();
        // random traffic
        for (int c = 0; c < 400; c++) begin
            bit from_owed;
            logic [4:0] r;
            idle();
            RegWriteW = ($urandom_range(0, 9) < 7) && !bubble;
            RdW = 5'($urandom_range(0, 31));
            ResultW = $urandom;
            r = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 9) < 3 && !pend[r]) begin
                issue_valid = 1; issue_rd = r;
            end
            from_owed = 0;
            if (owed.size() > 0 && $urandom_range(0, 1) == 1) begin
                lu_valid = 1; lu_rd = owed[0]; lu_data = $urandom; from_owed = 1;
            end else if ($urandom_range(0, 19) == 0) begin
                lu_valid = 1; lu_rd = 0; lu_data = $urandom;
            end
            Rs1D = 5'($urandom_range(0, 31));
            Rs2D = 5'($urandom_range(0, 31));
            RdD = 5'($urandom_range(0, 31));
            RegWriteD = 1'($urandom_range(0, 1));
            step();
            if (issue_valid) owed.push_back(issue_rd);
            if (pushed && from_owed) void'(owed.pop_front());
        end
        // 6: reset mid-operation
        idle();
        repeat (6) step();
        for (int k = 0; k < 32; k++) pend[k] = 0;
        q_rd.delete(); q_d.delete(); owed.delete();
        dut_reset_prep();
        issue(5'd5); issue(5'd8);
        RegWriteW = 1; RdW = 3; ResultW = 32'h3; lu_valid = 1; lu_rd = 5; lu_data = 32'h55; step();
        lu_rd = 8; lu_data = 32'h88; step();
        chk("pre_reset_pending", pending, 32'h0000_0120);
        chk("pre_reset_full", 32'(lu_ready), 32'd0);
        idle();
        #2 reset = 1;
        #1;
        chk("reset_pending", pending, 32'd0);
        chk("reset_lu_ready", 32'(lu_ready), 32'd1);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        model_clear();
        step();
        reset = 0;
        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
    task automatic dut_reset_prep();
        reset = 1;
        model_clear();
        step();
        reset = 0;
        step();
    endtask
endmodule
